// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around a 1-bit full-adder slice
// One operand bit per clock, LSB first; start/busy/done handshake with registered results.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic a_i, b_i, s_i, c_next;

   // The shared 1-bit slice: XOR-based full adder on the current bit.
   always_comb begin
      a_i    = a_r[cnt];
      b_i    = b_r[cnt];
      s_i    = a_i ^ b_i ^ carry;
      c_next = (a_i & b_i) | (carry & (a_i ^ b_i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         a_r      <= '0;
         b_r      <= '0;
         carry    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtract is a + ~b + 1: invert B once and seed the carry.
                  a_r   <= a;
                  b_r   <= b ^ {WIDTH{sub}};
                  carry <= sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sum[cnt] <= s_i;
               carry    <= c_next;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cout     <= c_next;
                  overflow <= carry ^ c_next;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized and directed bench for serial_add_ctrl
// Arithmetic/timestamp reference model with a per-cycle compare on the WIDTH=8 instance.
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   logic       start = 1'b0, sub = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, cout, overflow;
   logic [7:0] sum;

   logic       start2 = 1'b0, sub2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy2, done2, cout2, ovf2;
   logic [1:0] sum2;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: an operation accepted at edge number acc occupies edges acc..acc+8,
   // and its arithmetic result becomes visible at edge acc+8.
   int         cyc = 0;
   int         acc = -1000;
   bit         m_busy_before;
   int         sa, sb, r;
   logic [7:0] p_sum, v_sum = '0;
   logic       p_c, p_o, v_c = 1'b0, v_o = 1'b0;

   function automatic bit m_busy();
      return (cyc >= acc) && (cyc <= acc + 8);
   endfunction

   function automatic bit m_done();
      return cyc == acc + 8;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   = -1000;
         v_sum = '0;
         v_c   = 1'b0;
         v_o   = 1'b0;
      end else begin
         m_busy_before = m_busy();
         cyc++;
         if (!m_busy_before && start) begin
            acc = cyc;
            sa  = (a >= 8'd128) ? int'(a) - 256 : int'(a);
            sb  = (b >= 8'd128) ? int'(b) - 256 : int'(b);
            if (sub) begin
               r     = sa - sb;
               p_sum = 8'(int'(a) - int'(b));
               p_c   = (a >= b);
            end else begin
               r     = sa + sb;
               p_sum = 8'(int'(a) + int'(b));
               p_c   = (int'(a) + int'(b)) > 255;
            end
            p_o = (r > 127) || (r < -128);
         end
         if (cyc == acc + 8) begin
            v_sum = p_sum;
            v_c   = p_c;
            v_o   = p_o;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {31'd0, busy}, {31'd0, m_busy()});
         chk("done", {31'd0, done}, {31'd0, m_done()});
         if (!m_busy() || m_done()) begin
            chk("sum", {24'd0, sum}, {24'd0, v_sum});
            chk("cout", {31'd0, cout}, {31'd0, v_c});
            chk("overflow", {31'd0, overflow}, {31'd0, v_o});
         end
      end
   end

   // Called at posedge+1 with dut8 idle; returns at posedge+1 with dut8 idle again.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                      input logic [7:0] es, input logic ec, input logic eo, input string nm);
      int n;
      start = 1'b1; a = ta; b = tb; sub = ts;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, n, 8);
      chk({nm, "_sum"}, {24'd0, sum}, {24'd0, es});
      chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
      chk({nm, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
      @(posedge clk); #1;
   endtask

   task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic ts,
                      input logic [1:0] es, input logic ec, input logic eo, input string nm);
      int n;
      start2 = 1'b1; a2 = ta; b2 = tb; sub2 = ts;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, n, 2);
      chk({nm, "_sum"}, {30'd0, sum2}, {30'd0, es});
      chk({nm, "_cout"}, {31'd0, cout2}, {31'd0, ec});
      chk({nm, "_ovf"}, {31'd0, ovf2}, {31'd0, eo});
      @(posedge clk); #1;
      chk({nm, "_idle"}, {31'd0, busy2}, 32'd0);
   endtask

   initial begin
      int dn;
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_sum", {24'd0, sum}, 32'd0);
      chk("reset_cout", {31'd0, cout}, 32'd0);
      chk("reset_ovf", {31'd0, overflow}, 32'd0);
      chk("reset_busy2", {31'd0, busy2}, 32'd0);
      chk_en = 1'b1;
      rst_n  = 1'b1;

      op2(2'b11, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0, "w2_add");
      op2(2'b01, 2'b10, 1'b1, 2'b11, 1'b0, 1'b1, "w2_sub");

      op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add");
      op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap");
      op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "add_zero");
      op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_borrow");
      op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");

      // Start requests while busy must be ignored.
      start = 1'b1; a = 8'h01; b = 8'h02; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         if (done) dn++;
         if (k <= 8) chk("busy_held", {31'd0, busy}, 32'd1);
         start = (k <= 4);
         a = 8'hAA; b = 8'h55;
      end
      chk("busy_done_count", dn, 1);
      chk("busy_sum", {24'd0, sum}, 32'h03);
      chk("busy_released", {31'd0, busy}, 32'd0);
      op8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, "first_idle");

      // Reset while RUN is on bit 4.
      start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_no_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "after_rst");

      // Random traffic, including starts that land while busy.
      repeat (1500) begin
         start = ($urandom_range(0, 2) == 0);
         a     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         b     = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
         sub   = 1'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_idle", {31'd0, busy}, 32'd0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
